moda_lane_collector: RTL and testbench
======================================

// Module: moda_lane_collector
// PURPOSE
//   Downstream consumer of the moda instance array. Each moda lane produces an event strobe (o1) and a 2-bit code (o2).
//   This block captures per-lane events into sticky pending slots and arbitrates round-robin across lanes.
//   It presents one {lane, code} record at a time on a valid/ready output stream, and keeps per-lane overflow flags
//   plus a saturating accepted-record counter.
// PARAMETERS
//   LANES   4   number of moda lanes collected (>=2)
//   LW      2   lane index width, = $clog2(LANES)
//   CNT_W   8   width of accepted-record counter
// PORTS
//   clk       in   1         clock, all logic rising-edge
//   rst       in   1         asynchronous active-high reset
//   lane_vld  in   LANES     per-lane event strobe (moda o1), 1-cycle pulse
//   lane_dat  in   2*LANES   per-lane code (moda o2); lane i at [2i+1:2i]
//   out_vld   out  1         output record valid
//   out_rdy   in   1         downstream ready
//   out_lane  out  LW        lane index of current record
//   out_dat   out  2         code of current record
//   ovf       out  LANES     sticky per-lane overflow flag
//   ovf_clr   in   1         pulse: clear all ovf bits
//   evt_cnt   out  CNT_W     accepted records, saturating
// BEHAVIOUR
//   Reset (async, rst=1): pending=0, slot data=0, out_vld=0, out_lane=0, out_dat=0, ovf=0, evt_cnt=0, rr_ptr=0, state=IDLE.
//   Capture, per lane i, at each edge:
//   - lane_vld[i] & !pending[i]: pending[i]<=1, slot[i]<=lane_dat[i].
//   - lane_vld[i] & pending[i] & lane i not drained this cycle: ovf[i]<=1; slot[i] keeps its old value; new code dropped.
//   - lane_vld[i] & lane i drained this cycle: new code captured, pending stays 1, no overflow.
//   - ovf_clr and a new overflow in the same cycle: set wins for that lane; all other lanes clear.
//   Arbitration: round-robin among pending lanes, searching from rr_ptr upward with wrap (LANES-1 -> 0).
//   - On load of lane g: rr_ptr<=(g+1) mod LANES; pending[g] cleared unless re-set by a same-cycle lane_vld[g].
//   Output FSM (2 states):
//   - IDLE (out_vld=0): any pending -> load out_lane/out_dat from the winner, out_vld<=1, go HOLD. Otherwise stay.
//   - HOLD (out_vld=1): out_lane/out_dat stable while out_rdy=0.
//     - On out_vld&out_rdy: evt_cnt++ (holds at 2^CNT_W-1).
//     - If any lane is pending, load the next winner in the same edge and stay HOLD (throughput 1 record/cycle).
//     - Otherwise out_vld<=0 and go IDLE.
//   Latency: lane_vld at cycle N -> out_vld=1 at cycle N+2 when the output is idle.
//   Pending state is sampled before capture: an event arriving in cycle N is not eligible for arbitration in cycle N.
//   Reset asserted mid-operation clears everything immediately. Records in flight are lost, with no partial handshake.
//   Outputs are registered; there is no combinational path from out_rdy to out_vld.
// TESTING
//   1 Single event: lane_vld=4'b0100, lane_dat lane2=2'b11, out_rdy=1
//     -> cycle N+2: out_vld=1, out_lane=2, out_dat=3; one cycle later out_vld=0, evt_cnt=1.
//   2 All lanes together: lane_vld=4'b1111, codes 0,1,2,3, out_rdy=1
//     -> four back-to-back records, lanes 0,1,2,3, codes 0,1,2,3; evt_cnt=4, ovf=0.
//   3 Backpressure/overflow: out_rdy=0, lane1 events with code 1 then code 2
//     -> ovf[1]=1; when out_rdy=1, lane1 is delivered once with code 1; ovf_clr -> ovf=0.
//   4 Drain+capture collision: lane0 pending, lane0 granted in the same cycle a new lane0 event (code 2) arrives
//     -> no ovf; a second lane0 record with code 2 follows.
//   5 Round-robin fairness: lanes 0 and 3 re-fire every cycle, out_rdy=1
//     -> out_lane alternates 0,3,0,3; neither lane starves.
//   6 Reset mid-HOLD and saturation: assert rst with out_vld=1 -> all outputs 0 immediately.
//     With CNT_W=2, accept 5 records -> evt_cnt=3.

Source files
------------

// File: rtl/moda_lane_collector.sv
// Collects per-lane moda events into sticky slots and streams {lane, code} records round-robin.
// Two-cycle latency from lane_vld to out_vld; out_rdy low holds the record and extra events on a pending lane set ovf.
module moda_lane_collector #(
    parameter int LANES = 4,
    parameter int LW    = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANES-1:0]     lane_vld,
    input  logic [2*LANES-1:0]   lane_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [LW-1:0]        out_lane,
    output logic [1:0]           out_dat,
    output logic [LANES-1:0]     ovf,
    input  logic                 ovf_clr,
    output logic [CNT_W-1:0]     evt_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [LANES-1:0]     pend_q, pend_d;
    logic [2*LANES-1:0]   slot_q, slot_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [1:0]           dat_q, dat_d;
    logic [LANES-1:0]     ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]        rr_q, rr_d;

    logic [LW-1:0]        win;
    logic                 any_pend;
    logic                 load;
    logic                 accept;
    logic [LANES-1:0]     drain;
    logic [LANES-1:0]     ovf_set;

    // First pending lane at or above ptr, wrapping at LANES-1.
    function automatic logic [LW-1:0] pick(input logic [LANES-1:0] p, input logic [LW-1:0] ptr);
        logic [LW-1:0] w;
        logic          f;
        int            idx;
        w = ptr;
        f = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= LANES) idx = idx - LANES;
            if (!f && p[idx]) begin
                f = 1'b1;
                w = LW'(idx);
            end
        end
        return w;
    endfunction

    function automatic logic [LW-1:0] next_ptr(input logic [LW-1:0] g);
        if (int'(g) == LANES - 1) return '0;
        else return g + LW'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        lane_d   = lane_q;
        dat_d    = dat_q;
        rr_d     = rr_q;
        drain    = '0;
        cnt_d    = cnt_q;
        win      = pick(pend_q, rr_q);
        any_pend = |pend_q;
        accept   = (state_q == HOLD) && out_rdy;

        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_rdy) begin
                    if (any_pend) load = 1'b1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            lane_d     = win;
            dat_d      = slot_q[2*int'(win) +: 2];
            rr_d       = next_ptr(win);
            drain[win] = 1'b1;
        end

        if (accept && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    // A lane drained this edge may recapture without overflowing.
    always_comb begin
        pend_d  = pend_q;
        slot_d  = slot_q;
        ovf_set = '0;
        for (int i = 0; i < LANES; i++) begin
            pend_d[i]  = (pend_q[i] & ~drain[i]) | lane_vld[i];
            ovf_set[i] = lane_vld[i] & pend_q[i] & ~drain[i];
            if (lane_vld[i] & (~pend_q[i] | drain[i])) slot_d[2*i +: 2] = lane_dat[2*i +: 2];
        end
        ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            slot_q  <= '0;
            lane_q  <= '0;
            dat_q   <= '0;
            ovf_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            slot_q  <= slot_d;
            lane_q  <= lane_d;
            dat_q   <= dat_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    assign out_vld  = (state_q == HOLD);
    assign out_lane = lane_q;
    assign out_dat  = dat_q;
    assign ovf      = ovf_q;
    assign evt_cnt  = cnt_q;

endmodule

// File: tb/tb_moda_lane_collector.sv
// Bench for moda_lane_collector: directed scenarios plus random traffic against a record-level reference model.
module tb_moda_lane_collector;

    localparam int LANES = 4;
    localparam int LW    = 2;
    localparam int CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [LANES-1:0]     lane_vld;
    logic [2*LANES-1:0]   lane_dat;
    logic                 out_vld;
    logic                 out_rdy;
    logic [LW-1:0]        out_lane;
    logic [1:0]           out_dat;
    logic [LANES-1:0]     ovf;
    logic                 ovf_clr;
    logic [CNT_W-1:0]     evt_cnt;

    moda_lane_collector #(.LANES(LANES), .LW(LW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .lane_vld(lane_vld), .lane_dat(lane_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_lane(out_lane), .out_dat(out_dat),
        .ovf(ovf), .ovf_clr(ovf_clr), .evt_cnt(evt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one output record register, a pending flag and code per lane.
    bit             m_vld;
    int             m_lane, m_dat, m_rr, m_cnt;
    bit [LANES-1:0] m_pend, m_ovf;
    int             m_slot[LANES];

    task automatic model_reset();
        m_vld = 0; m_lane = 0; m_dat = 0; m_rr = 0; m_cnt = 0;
        m_pend = '0; m_ovf = '0;
        for (int i = 0; i < LANES; i++) m_slot[i] = 0;
    endtask

    task automatic model_edge();
        bit             accept, can_load;
        bit [LANES-1:0] old_pend;
        int             g;
        accept   = m_vld && out_rdy;
        can_load = !m_vld || out_rdy;
        old_pend = m_pend;
        g = -1;
        if (can_load)
            for (int k = 0; k < LANES; k++)
                if (g < 0 && old_pend[(m_rr + k) % LANES]) g = (m_rr + k) % LANES;
        if (accept && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (g >= 0) begin
            m_vld = 1; m_lane = g; m_dat = m_slot[g];
            m_rr = (g + 1) % LANES;
            m_pend[g] = 0;
        end else if (accept) begin
            m_vld = 0;
        end
        if (ovf_clr) m_ovf = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_vld[i]) begin
                if (old_pend[i] && i != g) m_ovf[i] = 1;
                else begin
                    m_slot[i] = int'(lane_dat[2*i +: 2]);
                    m_pend[i] = 1;
                end
            end
        end
    endtask

    task automatic cmp_all(input string ph);
        chk({ph, ".vld"}, 32'(out_vld), 32'(m_vld));
        if (m_vld) begin
            chk({ph, ".lane"}, 32'(out_lane), 32'(m_lane));
            chk({ph, ".dat"}, 32'(out_dat), 32'(m_dat));
        end
        chk({ph, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({ph, ".cnt"}, 32'(evt_cnt), 32'(m_cnt));
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        cmp_all(ph);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lane_vld = '0; lane_dat = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    int prev_lane;

    initial begin
        rst = 1'b1;
        lane_vld = '0; lane_dat = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cmp_all("reset");
        chk("reset.lane", 32'(out_lane), 0);
        chk("reset.dat", 32'(out_dat), 0);
        rst = 1'b0;

        // Single event on lane 2
        out_rdy = 1'b1;
        lane_vld = 4'b0100; lane_dat = 8'b0011_0000;
        step("t1");
        lane_vld = '0;
        step("t1");
        chk("t1.vld2", 32'(out_vld), 1);
        chk("t1.lane2", 32'(out_lane), 2);
        chk("t1.dat2", 32'(out_dat), 3);
        step("t1");
        chk("t1.vld3", 32'(out_vld), 0);
        chk("t1.cnt3", 32'(evt_cnt), 1);

        // All lanes at once
        do_reset();
        out_rdy = 1'b1;
        lane_vld = 4'b1111; lane_dat = 8'b11_10_01_00;
        step("t2");
        lane_vld = '0;
        for (int k = 0; k < LANES; k++) begin
            step("t2");
            chk("t2.lane", 32'(out_lane), 32'(k));
            chk("t2.dat", 32'(out_dat), 32'(k));
        end
        step("t2");
        chk("t2.vld", 32'(out_vld), 0);
        chk("t2.cnt", 32'(evt_cnt), 4);
        chk("t2.ovf", 32'(ovf), 0);

        // Backpressure and overflow on lane 1
        do_reset();
        lane_vld = 4'b0001; lane_dat = 8'b0;
        step("t3");
        lane_vld = 4'b0010; lane_dat = 8'b0000_0100;
        step("t3");
        lane_dat = 8'b0000_1000;
        step("t3");
        lane_vld = '0;
        chk("t3.ovf", 32'(ovf), 32'h2);
        out_rdy = 1'b1;
        step("t3");
        chk("t3.lane", 32'(out_lane), 1);
        chk("t3.dat", 32'(out_dat), 1);
        step("t3");
        chk("t3.vld", 32'(out_vld), 0);
        ovf_clr = 1'b1;
        step("t3");
        ovf_clr = 1'b0;
        chk("t3.clr", 32'(ovf), 0);
        chk("t3.cnt", 32'(evt_cnt), 2);

        // Drain and recapture on lane 0 in the same edge
        do_reset();
        lane_vld = 4'b0010; lane_dat = 8'b0000_0000;
        step("t4");
        lane_vld = 4'b0001; lane_dat = 8'b0000_0001;
        step("t4");
        lane_vld = '0;
        step("t4");
        out_rdy = 1'b1;
        lane_vld = 4'b0001; lane_dat = 8'b0000_0010;
        step("t4");
        lane_vld = '0;
        chk("t4.lane", 32'(out_lane), 0);
        chk("t4.dat", 32'(out_dat), 1);
        chk("t4.ovf", 32'(ovf), 0);
        step("t4");
        chk("t4.lane2", 32'(out_lane), 0);
        chk("t4.dat2", 32'(out_dat), 2);
        step("t4");
        chk("t4.vld", 32'(out_vld), 0);

        // Lanes 0 and 3 firing every cycle share the output
        do_reset();
        out_rdy = 1'b1;
        prev_lane = -1;
        for (int c = 0; c < 12; c++) begin
            lane_vld = 4'b1001; lane_dat = 8'($urandom);
            step("t5");
            if (out_vld) begin
                if (prev_lane >= 0) chk("t5.alt", 32'(int'(out_lane) != prev_lane), 1);
                prev_lane = int'(out_lane);
            end
        end
        lane_vld = '0;

        // Asynchronous reset while a record is held
        do_reset();
        lane_vld = 4'b0100; lane_dat = 8'b0010_0000;
        step("t6");
        lane_vld = '0;
        step("t6");
        chk("t6.held", 32'(out_vld), 1);
        rst = 1'b1;
        #1;
        model_reset();
        cmp_all("t6.rst");
        chk("t6.lane", 32'(out_lane), 0);
        chk("t6.dat", 32'(out_dat), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic, long enough to saturate the counter
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < LANES; i++) lane_vld[i] = ($urandom_range(0, 99) < 30);
            lane_dat = 8'($urandom);
            out_rdy  = ($urandom_range(0, 9) < 7);
            ovf_clr  = ($urandom_range(0, 19) == 0);
            step("rnd");
        end
        chk("sat.cnt", 32'(evt_cnt), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
